// File: rtl/usart_pkg.sv
// rtl/usart_pkg.sv - shared definitions for the two_usart loopback pair
// Contents: command codes, Control bit indices, TX/RX state encodings,
// and bit_period() mapping the divider select to cycles per bit.
package usart_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'b00,
    CMD_TX   = 2'b01,
    CMD_RX   = 2'b10,
    CMD_CFG  = 2'b11
  } cmd_t;

  // Control word layout; DIV is the low bit of a 2-bit field.
  localparam int DIV     = 0;
  localparam int PAR_EN  = 2;
  localparam int PAR_ODD = 3;
  localparam int STOP2   = 4;
  localparam int SYNC    = 5;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP1,
    TX_STOP2
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Bit period in CPU_Clk cycles: 4, 8, 16 or 32.
  function automatic logic [5:0] bit_period(input logic [1:0] sel);
    return 6'd4 << sel;
  endfunction

endpackage

// File: rtl/usart_core.sv
// rtl/usart_core.sv - one USART channel: frame transmitter plus frame receiver
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   div_sel, par_en,
//   par_odd, stop2        : frame format (only changed while channel idle)
//   tx_start, tx_data     : load a byte and begin a frame (honoured when idle)
//   tx_line, tx_idle      : serial output (idle 1), transmitter idle flag
//   rx_line               : serial input
//   rx_data, rx_idle      : last good received byte, receiver idle flag
module usart_core
  import usart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] div_sel,
  input  logic       par_en,
  input  logic       par_odd,
  input  logic       stop2,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_line,
  output logic       tx_idle,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_idle
);

  logic [5:0] n_last;
  logic [5:0] half_last;

  assign n_last    = bit_period(div_sel) - 6'd1;
  assign half_last = (bit_period(div_sel) >> 1) - 6'd1;

  // ---------------- transmitter ----------------
  tx_state_t  tx_state, tx_next;
  logic [5:0] tx_cnt;
  logic [2:0] tx_idx;
  logic [7:0] tx_shift;
  logic       tx_par;
  logic       tx_bit;
  logic       tx_tick;

  assign tx_tick = (tx_cnt == n_last);
  assign tx_idle = (tx_state == TX_IDLE);

  always_comb begin
    tx_next = tx_state;
    tx_bit  = 1'b1;
    case (tx_state)
      TX_IDLE:   if (tx_start) tx_next = TX_START;
      TX_START: begin
        tx_bit = 1'b0;
        if (tx_tick) tx_next = TX_DATA;
      end
      TX_DATA: begin
        tx_bit = tx_shift[0];
        if (tx_tick && tx_idx == 3'd7) tx_next = par_en ? TX_PARITY : TX_STOP1;
      end
      TX_PARITY: begin
        tx_bit = tx_par ^ par_odd;
        if (tx_tick) tx_next = TX_STOP1;
      end
      TX_STOP1:  if (tx_tick) tx_next = stop2 ? TX_STOP2 : TX_IDLE;
      TX_STOP2:  if (tx_tick) tx_next = TX_IDLE;
      default:   tx_next = TX_IDLE;
    endcase
  end

  // The line is registered from the current state, so it trails each state
  // change by one cycle: the start bit appears the cycle after acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_next;
      tx_line  <= tx_bit;
      if (tx_state == TX_IDLE) begin
        tx_cnt <= '0;
        tx_idx <= '0;
        if (tx_start) begin
          tx_shift <= tx_data;
          tx_par   <= ^tx_data;
        end
      end else begin
        tx_cnt <= tx_tick ? 6'd0 : tx_cnt + 6'd1;
        if (tx_state == TX_DATA && tx_tick) begin
          tx_shift <= tx_shift >> 1;
          tx_idx   <= tx_idx + 3'd1;
        end
      end
    end
  end

  // ---------------- receiver ----------------
  rx_state_t  rx_state, rx_next;
  logic [5:0] rx_cnt;
  logic [2:0] rx_idx;
  logic [7:0] rx_shift;
  logic       rx_par_err;
  logic       rx_commit;
  logic       rx_tick;

  // Start bit is checked half a period in; every later sample is a full period on.
  assign rx_tick = (rx_state == RX_START) ? (rx_cnt == half_last) : (rx_cnt == n_last);
  assign rx_idle = (rx_state == RX_IDLE);

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (!rx_line) rx_next = RX_START;
      RX_START:  if (rx_tick) rx_next = rx_line ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_tick && rx_idx == 3'd7) rx_next = par_en ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_tick) rx_next = RX_STOP;
      RX_STOP:   if (rx_tick) rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_par_err <= 1'b0;
      rx_commit  <= 1'b0;
      rx_data    <= '0;
    end else begin
      rx_state  <= rx_next;
      rx_commit <= 1'b0;
      // Publish one cycle after a good stop sample.
      if (rx_commit) rx_data <= rx_shift;
      if (rx_state == RX_IDLE) begin
        rx_cnt     <= '0;
        rx_idx     <= '0;
        rx_par_err <= 1'b0;
      end else begin
        rx_cnt <= rx_tick ? 6'd0 : rx_cnt + 6'd1;
        if (rx_tick) begin
          case (rx_state)
            RX_DATA: begin
              rx_shift <= {rx_line, rx_shift[7:1]};
              rx_idx   <= rx_idx + 3'd1;
            end
            RX_PARITY: rx_par_err <= ((^rx_shift) ^ par_odd) != rx_line;
            RX_STOP:   rx_commit  <= rx_line & ~rx_par_err;
            default:   ;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/two_usart.sv
// rtl/two_usart.sv - loopback USART pair with shared command/config interface
// Ports:
//   CPU_Clk, Reset        : clock, synchronous active-high reset
//   None, Rec, Trans      : command request and code {Rec,Trans}
//   Control               : frame format word written by the configure command
//   CPU_Data_in           : byte to transmit
//   InClk, ExClk          : internal bit clock, and its copy in synchronous mode
//   SLBit                 : serial line from channel A's transmitter
//   CPU_Data_out          : channel B's received byte, refreshed while receiving
module two_usart
  import usart_pkg::*;
(
  input  logic       CPU_Clk,
  input  logic       Reset,
  input  logic       None,
  input  logic       Rec,
  input  logic       Trans,
  input  logic [5:0] Control,
  input  logic [7:0] CPU_Data_in,
  output logic       InClk,
  output logic       ExClk,
  output logic       SLBit,
  output logic [7:0] CPU_Data_out
);

  cmd_t       code, code_q;
  logic       entry;
  logic [5:0] cfg;
  logic       cfg_we;
  logic       tx_go;
  logic [5:0] div_cnt;
  logic [5:0] div_half_last;

  logic       a_tx_idle, a_rx_idle, b_tx_idle, b_rx_idle;
  logic       b_tx_line;
  logic [7:0] b_rx_data;
  logic [7:0] unused_a_rx_data;

  assign code  = None ? cmd_t'({Rec, Trans}) : CMD_IDLE;
  // A command acts only on the cycle its code first appears.
  assign entry = (code != code_q);

  assign cfg_we = entry && (code == CMD_CFG) &&
                  a_tx_idle && a_rx_idle && b_tx_idle && b_rx_idle;
  assign tx_go  = entry && (code == CMD_TX) && a_tx_idle;

  assign div_half_last = (bit_period(cfg[DIV +: 2]) >> 1) - 6'd1;
  assign ExClk         = cfg[SYNC] & InClk;

  always_ff @(posedge CPU_Clk) begin
    if (Reset) begin
      code_q       <= CMD_IDLE;
      cfg          <= '0;
      div_cnt      <= '0;
      InClk        <= 1'b0;
      CPU_Data_out <= '0;
    end else begin
      code_q <= code;
      if (cfg_we) cfg <= Control;
      // Writing the config restarts the bit clock from a low phase.
      if (cfg_we) begin
        div_cnt <= '0;
        InClk   <= 1'b0;
      end else if (div_cnt == div_half_last) begin
        div_cnt <= '0;
        InClk   <= ~InClk;
      end else begin
        div_cnt <= div_cnt + 6'd1;
      end
      if (code == CMD_RX) CPU_Data_out <= b_rx_data;
    end
  end

  // Channel A only transmits; its receiver listens to B's quiet transmitter.
  usart_core u_a (
    .clk      (CPU_Clk),
    .reset    (Reset),
    .div_sel  (cfg[DIV +: 2]),
    .par_en   (cfg[PAR_EN]),
    .par_odd  (cfg[PAR_ODD]),
    .stop2    (cfg[STOP2]),
    .tx_start (tx_go),
    .tx_data  (CPU_Data_in),
    .tx_line  (SLBit),
    .tx_idle  (a_tx_idle),
    .rx_line  (b_tx_line),
    .rx_data  (unused_a_rx_data),
    .rx_idle  (a_rx_idle)
  );

  // Channel B only receives, from SLBit.
  usart_core u_b (
    .clk      (CPU_Clk),
    .reset    (Reset),
    .div_sel  (cfg[DIV +: 2]),
    .par_en   (cfg[PAR_EN]),
    .par_odd  (cfg[PAR_ODD]),
    .stop2    (cfg[STOP2]),
    .tx_start (1'b0),
    .tx_data  (8'h00),
    .tx_line  (b_tx_line),
    .tx_idle  (b_tx_idle),
    .rx_line  (SLBit),
    .rx_data  (b_rx_data),
    .rx_idle  (b_rx_idle)
  );

endmodule

// File: tb/tb_two_usart.sv
// tb/tb_two_usart.sv - self-checking bench for two_usart
module tb_two_usart;

  logic       CPU_Clk = 1'b0;
  logic       Reset;
  logic       None;
  logic       Rec;
  logic       Trans;
  logic [5:0] Control;
  logic [7:0] CPU_Data_in;
  logic       InClk;
  logic       ExClk;
  logic       SLBit;
  logic [7:0] CPU_Data_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [5:0] model_cfg;
  logic [7:0] model_rx;

  always #5 CPU_Clk = ~CPU_Clk;

  two_usart dut (
    .CPU_Clk      (CPU_Clk),
    .Reset        (Reset),
    .None         (None),
    .Rec          (Rec),
    .Trans        (Trans),
    .Control      (Control),
    .CPU_Data_in  (CPU_Data_in),
    .InClk        (InClk),
    .ExClk        (ExClk),
    .SLBit        (SLBit),
    .CPU_Data_out (CPU_Data_out)
  );

  task automatic test_reset();
    @(negedge CPU_Clk);
    Reset = 1'b1; None = 1'b0; Rec = 1'b0; Trans = 1'b0;
    Control = '0; CPU_Data_in = '0;
    @(negedge CPU_Clk);
    @(negedge CPU_Clk);
    n_cmp++; if (SLBit !== 1'b1) begin n_err++; $display("FAIL reset_slbit got %b want 1", SLBit); end
    n_cmp++; if (InClk !== 1'b0) begin n_err++; $display("FAIL reset_inclk got %b want 0", InClk); end
    n_cmp++; if (ExClk !== 1'b0) begin n_err++; $display("FAIL reset_exclk got %b want 0", ExClk); end
    n_cmp++; if (CPU_Data_out !== 8'h00) begin n_err++; $display("FAIL reset_data_out got %h want 00", CPU_Data_out); end
    Reset = 1'b0;
    model_cfg = '0;
    model_rx  = '0;
  endtask

  task automatic test_configure(input logic [5:0] c);
    @(negedge CPU_Clk);
    None = 1'b1; Rec = 1'b1; Trans = 1'b1; Control = c;
    @(negedge CPU_Clk);
    None = 1'b0; Rec = 1'b0; Trans = 1'b0;
    model_cfg = c;
  endtask

  // Transmit d with receive held afterwards; optionally inject one extra
  // command at cycle inj_t, which must not disturb the frame in flight.
  task automatic test_frame(input string name, input logic [7:0] d, input int inj_t,
                            input logic [1:0] inj_cmd, input logic [7:0] inj_data,
                            input logic [5:0] inj_ctl);
    int n;
    int len;
    int t_upd;
    logic bits[$];
    logic exp_line;
    logic [7:0] exp_out;
    n = 4 << model_cfg[1:0];
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (model_cfg[2]) bits.push_back((^d) ^ model_cfg[3]);
    bits.push_back(1'b1);
    if (model_cfg[4]) bits.push_back(1'b1);
    len   = n * bits.size();
    t_upd = 4 + n * (9 + int'(model_cfg[2])) + n / 2;

    @(negedge CPU_Clk);
    None = 1'b1; Rec = 1'b0; Trans = 1'b1; CPU_Data_in = d;
    @(negedge CPU_Clk);
    n_cmp++; if (SLBit !== 1'b1) begin n_err++; $display("FAIL %s accept_edge_line got %b want 1", name, SLBit); end
    Rec = 1'b1; Trans = 1'b0;
    for (int t = 1; t <= len + n; t++) begin
      @(negedge CPU_Clk);
      exp_line = (t <= len) ? bits[(t - 1) / n] : 1'b1;
      exp_out  = (t >= t_upd) ? d : model_rx;
      n_cmp++;
      if (SLBit !== exp_line) begin
        n_err++; $display("FAIL %s line t=%0d got %b want %b", name, t, SLBit, exp_line);
      end
      n_cmp++;
      if (CPU_Data_out !== exp_out) begin
        n_err++; $display("FAIL %s data_out t=%0d got %h want %h", name, t, CPU_Data_out, exp_out);
      end
      if (t == inj_t) begin
        {Rec, Trans} = inj_cmd; CPU_Data_in = inj_data; Control = inj_ctl;
      end else if (t == inj_t + 1) begin
        Rec = 1'b1; Trans = 1'b0;
      end
    end
    model_rx = d;
    None = 1'b0; Rec = 1'b0; Trans = 1'b0;
  endtask

  task automatic test_sync(input string name, input logic [5:0] c);
    int h;
    logic exp_in;
    h = (4 << c[1:0]) / 2;
    @(negedge CPU_Clk);
    None = 1'b1; Rec = 1'b1; Trans = 1'b1; Control = c;
    @(negedge CPU_Clk);
    None = 1'b0; Rec = 1'b0; Trans = 1'b0;
    model_cfg = c;
    for (int t = 0; t < 32; t++) begin
      exp_in = ((t / h) % 2) == 1;
      n_cmp++;
      if (InClk !== exp_in) begin
        n_err++; $display("FAIL %s inclk t=%0d got %b want %b", name, t, InClk, exp_in);
      end
      n_cmp++;
      if (ExClk !== (c[5] & exp_in)) begin
        n_err++; $display("FAIL %s exclk t=%0d got %b want %b", name, t, ExClk, c[5] & exp_in);
      end
      @(negedge CPU_Clk);
    end
  endtask

  task automatic test_reset_midframe(input logic [7:0] d);
    int n;
    int len;
    n   = 4 << model_cfg[1:0];
    len = n * (10 + int'(model_cfg[2]) + int'(model_cfg[4]));
    @(negedge CPU_Clk);
    None = 1'b1; Rec = 1'b0; Trans = 1'b1; CPU_Data_in = d;
    @(negedge CPU_Clk);
    Rec = 1'b1; Trans = 1'b0;
    repeat (len / 2) @(negedge CPU_Clk);
    Reset = 1'b1;
    @(negedge CPU_Clk);
    n_cmp++; if (SLBit !== 1'b1) begin n_err++; $display("FAIL midreset_line got %b want 1", SLBit); end
    n_cmp++; if (CPU_Data_out !== 8'h00) begin n_err++; $display("FAIL midreset_data_out got %h want 00", CPU_Data_out); end
    Reset = 1'b0;
    model_cfg = '0;
    model_rx  = '0;
    for (int t = 0; t < len + n; t++) begin
      @(negedge CPU_Clk);
      n_cmp++;
      if (SLBit !== 1'b1 || CPU_Data_out !== 8'h00) begin
        n_err++; $display("FAIL midreset_quiet t=%0d got line %b data %h want 1 00", t, SLBit, CPU_Data_out);
      end
    end
    None = 1'b0; Rec = 1'b0; Trans = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; None = 1'b0; Rec = 1'b0; Trans = 1'b0;
    Control = '0; CPU_Data_in = '0;
    model_cfg = '0; model_rx = '0;

    test_reset();

    test_configure(6'b011001);
    test_frame("n8_2stop_a5", 8'hA5, -1, 2'b00, 8'h00, 6'b000000);

    test_configure(6'b001101);
    test_frame("n8_odd_03", 8'h03, -1, 2'b00, 8'h00, 6'b000000);

    test_configure(6'b000001);
    test_frame("busy_tx_drop", 8'h5A, 20, 2'b01, 8'h11, 6'b000001);

    test_frame("busy_cfg", 8'hC3, 20, 2'b11, 8'h00, 6'b000011);
    test_frame("after_busy_cfg", 8'h3C, -1, 2'b00, 8'h00, 6'b000000);

    test_sync("sync_on", 6'b111101);
    test_sync("sync_off", 6'b001101);

    for (int k = 0; k < 8; k++) begin
      test_configure(6'($urandom_range(0, 63)));
      test_frame("random", 8'($urandom), -1, 2'b00, 8'h00, 6'b000000);
    end

    test_configure(6'b000101);
    test_frame("pre_reset", 8'h96, -1, 2'b00, 8'h00, 6'b000000);
    test_reset_midframe(8'($urandom) | 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/two_usart.md
# two_usart

Loopback pair of USART channels sharing one CPU-side register interface. CPU writes are serialized by the transmit channel onto `SLBit`, and the receive channel deserializes the same line back into a data register. Both channels use one shared, programmable frame format. The block sits between the CPU bus and a serial test line, and exposes its internal and external bit clocks for observation.

## Interface
Parameters: none.
- `CPU_Clk` in 1: the single clock; all state updates on its rising edge.
- `Reset` in 1: reset is synchronous and active-high.
- `None` in 1: 0 = no request, all commands ignored; 1 = command given by `{Rec,Trans}`.
- `Rec` in 1: command bit.
- `Trans` in 1: command bit. `{Rec,Trans}`: 01 = transmit, 10 = receive, 11 = configure, 00 = idle.
- `Control` in 6: configuration word.
  - [1:0] divider select, bit period N = 4<<Control[1:0] cycles (4/8/16/32).
  - [2] parity enable; [3] odd parity; [4] two stop bits; [5] synchronous mode.
- `CPU_Data_in` in 8: transmit data.
- `InClk` out 1: internal bit clock, square wave of period N.
- `ExClk` out 1: equals `InClk` when synchronous mode is set, otherwise 0.
- `SLBit` out 1: serial line, idle 1.
- `CPU_Data_out` out 8: received data presented to the CPU.

## Operation
- Command decode is registered each cycle. A command is accepted only on its entry cycle, i.e. the first cycle the decoded code differs from the previous cycle's code.
- **Configure:** latches `Control` into the config register only if both TX and RX are idle; otherwise ignored. Reset value of the config register is 6'b000000 (N = 4, 8N1, async).
- **Transmit:** accepted only if TX is idle, loading `CPU_Data_in` into the shift register. Ignored (data dropped) if TX is busy.
- **TX FSM:** IDLE → START → DATA(8, LSB first) → PARITY (if enabled) → STOP1 → STOP2 (if two stop bits) → IDLE. Each state lasts exactly N cycles.
- Parity bit is the XOR of the data bits; it is inverted when odd parity is selected.
- **RX FSM:** IDLE → START → DATA → PARITY → STOP → IDLE.
  - In IDLE, `SLBit` = 0 starts a frame.
  - Start bit is sampled at N/2; the frame is aborted to IDLE if it reads 1.
  - Each following bit is sampled every N cycles thereafter.
  - If the stop sample is 1, the RX data register is updated; if it is 0 (framing error), the frame is discarded.
  - A parity mismatch discards the frame. Only the first stop bit is checked.
- **Receive:** while the code is 10, `CPU_Data_out` tracks the RX data register. Otherwise it holds its last value.
- **Reset values:** `SLBit` = 1, `InClk` = 0, `ExClk` = 0, `CPU_Data_out` = 0, RX data = 0, both FSMs IDLE. Reset mid-frame aborts immediately.

## Timing
- **TX:** the accept edge is cycle 0. `SLBit` goes low at cycle 1, and each bit starts N cycles after the previous one. Frame length is N·(10 + P + S2), where P = parity enable and S2 = two-stop-bit enable.
- **RX:**
  - Start detect is registered one cycle after `SLBit` falls.
  - The stop sample lands at detect + N·(9 + P) + N/2.
  - The RX data register is updated the cycle after the stop sample.
  - `CPU_Data_out` reflects the update one cycle later if receive is active.
- `InClk` runs free from reset as a divide-by-N toggle of `CPU_Clk`. A config change restarts its divider.
- Simultaneous transmit accept and RX completion is legal; the two channels are independent.

## Structure
- Shared package `usart_pkg`:
  - command codes: CMD_IDLE, CMD_TX, CMD_RX, CMD_CFG;
  - Control bit indices: DIV, PAR_EN, PAR_ODD, STOP2, SYNC;
  - TX/RX state enums;
  - function returning N from the divider select.
- Sub-module `usart_core`: one TX+RX channel with config inputs.
  - `two_usart` instantiates it twice: instance A's TX drives `SLBit`, and instance B's RX samples `SLBit`.
  - The command decoder and config register stay at the top level.

## Test plan
- Reset, then configure `Control` = 011001 (N = 8, no parity, 2 stop), then transmit 0xA5 → `SLBit` carries 0,1,0,1,0,0,1,0,1,1,1, each bit 8 cycles. Receive then shows `CPU_Data_out` = 0xA5.
- Configure 001101 (N = 8, odd parity, 1 stop), then transmit 0x03 → parity bit = 1, frame is 11 bits (88 cycles), and 0x03 is received.
- Transmit 0x11 while a previous frame is in flight → the command is ignored, and only the first byte appears on `SLBit`.
- Configure with 1x1101 (sync mode) → `ExClk` equals `InClk`, with period 8 cycles. Configure with the sync bit 0 → `ExClk` = 0.
- Assert `Reset` mid-frame → the next cycle has `SLBit` = 1, `CPU_Data_out` = 0, and no RX update.
- Issue configure while TX is busy → the config is unchanged, and the frame timing stays at the old N.
